product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N_TERMS, default 8, SHALL set the number of products summed per output result (legal range 1..256).
REQ-002 Parameter ACC_W, default 20, SHALL set the accumulator and result width in bits (legal range 16..32).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 product  input  16  SHALL carry the unsigned 16-bit product from the upstream mult16 result port.
REQ-006 prod_valid  input  1  SHALL mark product as valid.
REQ-007 prod_ready  output  1  SHALL indicate the block can accept a product this cycle.
REQ-008 acc_out  output  ACC_W  SHALL carry the unsigned sum of one completed group.
REQ-009 out_valid  output  1  SHALL mark acc_out as valid.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer accepts acc_out.
REQ-011 overflow  output  1  SHALL flag that the current or last group exceeded 2^ACC_W-1.

Function
REQ-012 A product beat SHALL transfer only on a rising edge where prod_valid=1 and prod_ready=1.
REQ-013 FSM states SHALL be IDLE, ACCUM and DONE, with a term counter cnt of width clog2(N_TERMS)+1.
REQ-014 IDLE: prod_ready=1, out_valid=0; on a transfer the accumulator SHALL load product (not add it), cnt SHALL become 1, and the state SHALL go to ACCUM, or to DONE when N_TERMS=1.
REQ-015 ACCUM: prod_ready=1; on a transfer the accumulator SHALL add zero-extended product and cnt SHALL increment; when the beat is the N_TERMS-th, the state SHALL go to DONE.
REQ-016 ACCUM with no transfer SHALL hold the accumulator, cnt and state unchanged, with no timeout.
REQ-017 DONE: prod_ready=0, out_valid=1, and acc_out SHALL equal the group sum, stable until accepted.
REQ-018 DONE with out_ready=1 SHALL return to IDLE on that edge; out_valid SHALL drop the following cycle.
REQ-019 DONE with out_ready=0 SHALL hold all outputs unchanged, with no data loss.
REQ-020 Latency: out_valid SHALL rise on the first cycle after the edge that accepted the N_TERMS-th product.
REQ-021 Maximum throughput SHALL be N_TERMS accepted products per N_TERMS+1 cycles when out_ready is tied high.
REQ-022 No product SHALL be accepted in DONE, even when out_ready=1 in the same cycle.
REQ-023 acc_out SHALL be driven from the accumulator register, with no combinational path from product.
REQ-024 overflow SHALL be cleared on the first beat of each group.

Reset
REQ-025 reset=0 at a rising edge SHALL force: state IDLE, cnt=0, accumulator=0, acc_out=0, out_valid=0, overflow=0, and prod_ready=1 from the next cycle.
REQ-026 Reset mid-group or in DONE SHALL discard partial or pending results, with no output beat produced.
REQ-027 Reset SHALL take priority over any simultaneous product or output handshake.

Configuration
REQ-028 Macro PRODUCT_ACC_SAT_EN, when defined, SHALL make additions saturate at 2^ACC_W-1 and SHALL set overflow sticky for the group on any saturating add.
REQ-029 Without PRODUCT_ACC_SAT_EN, additions SHALL wrap modulo 2^ACC_W and overflow SHALL be constant 0.

Verification
REQ-030 N_TERMS=2: products 4 then 100, each valid one cycle -> acc_out=104, out_valid one cycle after the 2nd beat, overflow=0.
REQ-031 N_TERMS=8: eight beats of 0xFFFF back-to-back, out_ready=1 -> acc_out=0x7FFF8, overflow=0, prod_ready=0 for exactly one cycle.
REQ-032 N_TERMS=2, out_ready=0 for 5 cycles after the result, with prod_valid held high -> acc_out=104 held and prod_ready=0 throughout; the next group starts only after acceptance.
REQ-033 N_TERMS=4: reset pulsed after 2 beats, then products 1,2,3,4 -> single result acc_out=10, with no stale result.
REQ-034 ACC_W=16, N_TERMS=2, products 0xFFFF and 0x0002 -> with PRODUCT_ACC_SAT_EN: acc_out=0xFFFF, overflow=1; without: acc_out=0x0001, overflow=0.
REQ-035 N_TERMS=1: product 0x0064 -> acc_out=100 the next cycle, with prod_ready=0 while out_valid=1.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Product accumulator bus: the upstream product stream and the downstream
// result stream with its overflow flag. The accumulator itself is the slave.
interface product_accumulator_if #(
  parameter int ACC_W = 20
);
  logic [15:0]      product;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (
    output product, prod_valid, out_ready,
    input  prod_ready, acc_out, out_valid, overflow
  );

  modport slave (
    input  product, prod_valid, out_ready,
    output prod_ready, acc_out, out_valid, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Product accumulator: sums N_TERMS unsigned 16-bit products per group and
// presents the group sum with a valid/ready handshake. The result is held
// in DONE until the consumer takes it, and no product is taken meanwhile.
// Optional feature macro: PRODUCT_ACC_SAT_EN -- when defined, additions
// saturate at 2^ACC_W-1 and overflow becomes sticky for the group; when
// undefined, additions wrap and overflow is tied low.
module product_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 20
) (
  input logic                  clk,
  input logic                  reset,
  product_accumulator_if.slave bus
);

  localparam int              CNT_W  = $clog2(N_TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);
  localparam bit              SINGLE = (N_TERMS == 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             prod_ready;
  logic             out_valid;
  logic             load;
  logic             add;

`ifdef PRODUCT_ACC_SAT_EN
  logic [ACC_W:0] sum_ext;
  logic           sat_hit;
  logic           ovf;

  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(bus.product);
  assign sat_hit = sum_ext[ACC_W];
  assign acc_sum = sat_hit ? '1 : sum_ext[ACC_W-1:0];
  assign bus.overflow = ovf;
`else
  assign acc_sum = acc + ACC_W'(bus.product);
  assign bus.overflow = 1'b0;
`endif

  assign bus.prod_ready = prod_ready;
  assign bus.out_valid  = out_valid;
  assign bus.acc_out    = acc;

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and datapath strobes for the current state.
  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    add        = 1'b0;
    case (state)
      IDLE: begin
        prod_ready = 1'b1;
        if (bus.prod_valid) begin
          load      = 1'b1;
          state_nxt = SINGLE ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (bus.prod_valid) begin
          add = 1'b1;
          if (cnt == LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator, term counter and overflow flag: load on a group's first
  // beat, add on later beats, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
`ifdef PRODUCT_ACC_SAT_EN
      ovf <= 1'b0;
`endif
    end else if (load) begin
      cnt <= CNT_W'(1);
      acc <= ACC_W'(bus.product);
`ifdef PRODUCT_ACC_SAT_EN
      ovf <= 1'b0;
`endif
    end else if (add) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_sum;
`ifdef PRODUCT_ACC_SAT_EN
      ovf <= ovf | sat_hit;
`endif
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator. Four instances with different group
// sizes and widths share one stimulus stream; a group-sum reference model
// per instance predicts handshakes, results and overflow.
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic [15:0] stim_product;
  logic        stim_valid;
  logic        stim_out_ready;

  int n_checks;
  int n_fail;

  // Instance configuration: index 0..3
  int n_terms [4] = '{8, 2, 4, 1};
  int acc_w   [4] = '{20, 16, 20, 20};

  // Reference model: per instance, beats taken in the open group, their
  // plain integer sum, whether a finished result awaits acceptance, and the
  // overflow outcome of the last accepted group.
  int     m_cnt      [4];
  longint m_sum      [4];
  bit     m_pend     [4];
  bit     m_last_ovf [4];

  logic        obs_ready [4];
  logic        obs_valid [4];
  logic        obs_ovf   [4];
  logic [31:0] obs_acc   [4];

  product_accumulator_if #(.ACC_W(20)) bus0 ();
  product_accumulator_if #(.ACC_W(16)) bus1 ();
  product_accumulator_if #(.ACC_W(20)) bus2 ();
  product_accumulator_if #(.ACC_W(20)) bus3 ();

  assign bus0.product = stim_product;
  assign bus1.product = stim_product;
  assign bus2.product = stim_product;
  assign bus3.product = stim_product;
  assign bus0.prod_valid = stim_valid;
  assign bus1.prod_valid = stim_valid;
  assign bus2.prod_valid = stim_valid;
  assign bus3.prod_valid = stim_valid;
  assign bus0.out_ready = stim_out_ready;
  assign bus1.out_ready = stim_out_ready;
  assign bus2.out_ready = stim_out_ready;
  assign bus3.out_ready = stim_out_ready;

  assign obs_ready[0] = bus0.prod_ready;
  assign obs_ready[1] = bus1.prod_ready;
  assign obs_ready[2] = bus2.prod_ready;
  assign obs_ready[3] = bus3.prod_ready;
  assign obs_valid[0] = bus0.out_valid;
  assign obs_valid[1] = bus1.out_valid;
  assign obs_valid[2] = bus2.out_valid;
  assign obs_valid[3] = bus3.out_valid;
  assign obs_ovf[0] = bus0.overflow;
  assign obs_ovf[1] = bus1.overflow;
  assign obs_ovf[2] = bus2.overflow;
  assign obs_ovf[3] = bus3.overflow;
  assign obs_acc[0] = 32'(bus0.acc_out);
  assign obs_acc[1] = 32'(bus1.acc_out);
  assign obs_acc[2] = 32'(bus2.acc_out);
  assign obs_acc[3] = 32'(bus3.acc_out);

  product_accumulator #(.N_TERMS(8), .ACC_W(20)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  product_accumulator #(.N_TERMS(2), .ACC_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  product_accumulator #(.N_TERMS(4), .ACC_W(20)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  product_accumulator #(.N_TERMS(1), .ACC_W(20)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint max_of(input int k);
    return (longint'(1) << acc_w[k]) - 1;
  endfunction

  // Expected result: the group sum clipped or wrapped into ACC_W bits
  function automatic logic [31:0] exp_acc(input int k);
`ifdef PRODUCT_ACC_SAT_EN
    return 32'((m_sum[k] > max_of(k)) ? max_of(k) : m_sum[k]);
`else
    return 32'(m_sum[k] & max_of(k));
`endif
  endfunction

  // Expected overflow: the open group's status, or the last group's when idle
  function automatic logic exp_ovf(input int k);
`ifdef PRODUCT_ACC_SAT_EN
    if (m_cnt[k] > 0 || m_pend[k]) return m_sum[k] > max_of(k);
    return m_last_ovf[k];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_val(input string tag, input int k,
                           input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k]      = 0;
      m_sum[k]      = 0;
      m_pend[k]     = 1'b0;
      m_last_ovf[k] = 1'b0;
    end
  endtask

  // Compare every instance against the model state before the next edge
  task automatic checkOutput();
    for (int k = 0; k < 4; k++) begin
      check_val("prod_ready", k, 32'(obs_ready[k]), 32'(!m_pend[k]));
      check_val("out_valid", k, 32'(obs_valid[k]), 32'(m_pend[k]));
      check_val("overflow", k, 32'(obs_ovf[k]), 32'(exp_ovf(k)));
      if (m_pend[k]) check_val("acc_out", k, obs_acc[k], exp_acc(k));
    end
  endtask

  // One cycle: check, drive inputs, advance the model across the coming edge
  task automatic applyStimulus(input logic [15:0] p, input logic v,
                               input logic r, input logic rs);
    checkOutput();
    stim_product   = p;
    stim_valid     = v;
    stim_out_ready = r;
    reset          = rs;
    for (int k = 0; k < 4; k++) begin
      if (!rs) begin
        m_cnt[k]      = 0;
        m_sum[k]      = 0;
        m_pend[k]     = 1'b0;
        m_last_ovf[k] = 1'b0;
      end else if (m_pend[k] && r) begin
`ifdef PRODUCT_ACC_SAT_EN
        m_last_ovf[k] = m_sum[k] > max_of(k);
`endif
        m_pend[k] = 1'b0;
        m_cnt[k]  = 0;
        m_sum[k]  = 0;
      end else if (!m_pend[k] && v) begin
        m_sum[k] = m_sum[k] + longint'(p);
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == n_terms[k]) m_pend[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    logic [15:0] p;
    logic        v;
    logic        r;
    logic        rs;

    n_checks       = 0;
    n_fail         = 0;
    stim_product   = '0;
    stim_valid     = 1'b0;
    stim_out_ready = 1'b0;
    reset          = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();

    for (int k = 0; k < 4; k++) begin
      check_val("reset_acc", k, obs_acc[k], 32'h0);
      check_val("reset_ovf", k, 32'(obs_ovf[k]), 32'h0);
    end

    // Two-term group 4 + 100
    applyStimulus(16'd4, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'd100, 1'b1, 1'b1, 1'b1);
    check_val("pair_valid", 1, 32'(obs_valid[1]), 32'h1);
    check_val("pair_acc", 1, obs_acc[1], 32'd104);
    check_val("pair_ovf", 1, 32'(obs_ovf[1]), 32'h0);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b1);

    // Eight back-to-back 0xFFFF beats with the consumer always ready
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b0);
    repeat (8) applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
    check_val("full_acc", 0, obs_acc[0], 32'h7FFF8);
    check_val("full_ovf", 0, 32'(obs_ovf[0]), 32'h0);
    check_val("full_ready_low", 0, 32'(obs_ready[0]), 32'h0);
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
    check_val("full_ready_back", 0, 32'(obs_ready[0]), 32'h1);
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);

    // Stalled consumer with products still offered
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'd4, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_acc", 1, obs_acc[1], 32'd104);
      check_val("stall_ready", 1, 32'(obs_ready[1]), 32'h0);
      applyStimulus(16'd7, 1'b1, 1'b0, 1'b1);
    end
    check_val("stall_acc", 1, obs_acc[1], 32'd104);
    applyStimulus(16'd7, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'd9, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd1, 1'b1, 1'b0, 1'b1);
    check_val("after_stall_acc", 1, obs_acc[1], 32'd10);

    // Reset in the middle of a four-term group
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'd5, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd6, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 1'b1, 1'b0, 1'b1);
    check_val("midreset_valid", 2, 32'(obs_valid[2]), 32'h1);
    check_val("midreset_acc", 2, obs_acc[2], 32'd10);

    // 16-bit accumulator pushed past its range
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h0002, 1'b1, 1'b0, 1'b1);
`ifdef PRODUCT_ACC_SAT_EN
    check_val("range_acc", 1, obs_acc[1], 32'hFFFF);
    check_val("range_ovf", 1, 32'(obs_ovf[1]), 32'h1);
`else
    check_val("range_acc", 1, obs_acc[1], 32'h0001);
    check_val("range_ovf", 1, 32'(obs_ovf[1]), 32'h0);
`endif

    // Single-term groups
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0064, 1'b1, 1'b0, 1'b1);
    check_val("single_valid", 3, 32'(obs_valid[3]), 32'h1);
    check_val("single_acc", 3, obs_acc[3], 32'd100);
    check_val("single_ready", 3, 32'(obs_ready[3]), 32'h0);

    // Random traffic, with large products favoured to exercise overflow
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 60) != 0);
      applyStimulus(p, v, r, rs);
    end
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
